// File: rtl/eq_gain_scheduler.sv
// Six-band EQ gain store; edits mark bands dirty, one dirty band is pushed to the DSP per sample gap.
// Load latency: 1 cycle after i_dsp_done, held SET_CYC cycles; i_doneR aborts. Optional EQ_FLAT_EN adds i_flat.
module eq_gain_scheduler #(
    parameter int          NUM_BANDS  = 6,
    parameter logic [15:0] GAIN_UNITY = 16'h8000,
    parameter logic [15:0] GAIN_STEP  = 16'h0800,
    parameter logic [15:0] GAIN_MIN   = 16'h0000,
    parameter logic [15:0] GAIN_MAX   = 16'hF000,
    parameter int          SET_CYC    = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [2:0]  i_band,
    input  logic        i_inc,
    input  logic        i_dec,
    input  logic        i_dsp_done,
    input  logic        i_doneR,
`ifdef EQ_FLAT_EN
    input  logic        i_flat,
`endif
    output logic [15:0] o_gain,
    output logic [2:0]  o_set_gain,
    output logic [15:0] o_gain_view,
    output logic        o_pending
);

    typedef enum logic {S_IDLE, S_LOAD} state_t;

    state_t               state_q;
    logic [15:0]          gain_q [NUM_BANDS];
    logic [15:0]          gain_d [NUM_BANDS];
    logic [NUM_BANDS-1:0] dirty_q, dirty_d;
    logic [NUM_BANDS-1:0] edit_mask, load_mask;
    logic [2:0]           last_q, set_gain_q;
    logic [15:0]          gain_out_q;
    logic [7:0]           cnt_q;
    logic                 redirty_q;

    logic        flat;
    logic        band_vld, edit, complete, pick_vld, hit_load, hit_pick;
    logic [2:0]  band_idx, set_idx, pick_idx;
    logic [15:0] cur_gain, inc_val, dec_val, edit_val;
    logic [16:0] inc_sum, dec_diff;
    int          j;

`ifdef EQ_FLAT_EN
    assign flat = i_flat;
`else
    assign flat = 1'b0;
`endif

    assign band_vld = (i_band != 3'd0) && (int'(i_band) <= NUM_BANDS);
    assign band_idx = i_band - 3'd1;
    assign set_idx  = set_gain_q - 3'd1;
    assign cur_gain = band_vld ? gain_q[band_idx] : 16'd0;

    // Saturating arithmetic in 17 bits so a step never wraps past either bound.
    assign inc_sum  = {1'b0, cur_gain} + {1'b0, GAIN_STEP};
    assign dec_diff = {1'b0, cur_gain} - {1'b0, GAIN_STEP};
    assign inc_val  = (inc_sum > {1'b0, GAIN_MAX}) ? GAIN_MAX : inc_sum[15:0];
    assign dec_val  = (dec_diff[16] || (dec_diff[15:0] < GAIN_MIN)) ? GAIN_MIN : dec_diff[15:0];
    assign edit_val = i_inc ? inc_val : dec_val;
    assign edit     = band_vld && (i_inc ^ i_dec) && !flat;

    assign edit_mask = NUM_BANDS'(1) << band_idx;
    assign load_mask = NUM_BANDS'(1) << set_idx;
    assign complete  = (state_q == S_LOAD) && !i_doneR && (cnt_q == 8'(SET_CYC));
    assign hit_load  = flat || (edit && (i_band == set_gain_q));
    assign hit_pick  = flat || (edit && (band_idx == pick_idx));

    always_comb begin
        for (int k = 0; k < NUM_BANDS; k++) begin
            gain_d[k] = gain_q[k];
            if (flat)
                gain_d[k] = GAIN_UNITY;
            else if (edit && (int'(band_idx) == k))
                gain_d[k] = edit_val;
        end
    end

    // An edit or flat landing on the band in flight keeps it dirty past completion.
    always_comb begin
        dirty_d = dirty_q;
        if (complete && !redirty_q)
            dirty_d = dirty_d & ~load_mask;
        if (edit)
            dirty_d = dirty_d | edit_mask;
        if (flat)
            dirty_d = '1;
    end

    // Rotating search starts at the band after the last one fully loaded.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = 3'd0;
        j        = 0;
        for (int k = 0; k < NUM_BANDS; k++) begin
            j = (int'(last_q) + k) % NUM_BANDS;
            if (!pick_vld && dirty_q[j]) begin
                pick_vld = 1'b1;
                pick_idx = 3'(j);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            for (int k = 0; k < NUM_BANDS; k++)
                gain_q[k] <= GAIN_UNITY;
            dirty_q    <= '1;
            last_q     <= 3'd0;
            set_gain_q <= 3'd0;
            gain_out_q <= 16'd0;
            cnt_q      <= 8'd0;
            redirty_q  <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_BANDS; k++)
                gain_q[k] <= gain_d[k];
            dirty_q <= dirty_d;
            case (state_q)
                S_IDLE: begin
                    if (i_dsp_done && !i_doneR && pick_vld) begin
                        state_q    <= S_LOAD;
                        set_gain_q <= pick_idx + 3'd1;
                        gain_out_q <= gain_q[pick_idx];
                        cnt_q      <= 8'd1;
                        redirty_q  <= hit_pick;
                    end
                end
                S_LOAD: begin
                    if (hit_load)
                        redirty_q <= 1'b1;
                    if (i_doneR) begin
                        state_q    <= S_IDLE;
                        set_gain_q <= 3'd0;
                        cnt_q      <= 8'd0;
                    end else if (complete) begin
                        state_q    <= S_IDLE;
                        last_q     <= set_gain_q;
                        set_gain_q <= 3'd0;
                        cnt_q      <= 8'd0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_gain      = gain_out_q;
    assign o_set_gain  = set_gain_q;
    assign o_gain_view = cur_gain;
    assign o_pending   = |dirty_q;

endmodule

// File: tb/tb_eq_gain_scheduler.sv
// Directed bench for eq_gain_scheduler: reset, full sync, saturation, rotation, abort, mid-load edit, flat.
module tb_eq_gain_scheduler;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [2:0]  i_band = 3'd0;
    logic        i_inc = 1'b0;
    logic        i_dec = 1'b0;
    logic        i_dsp_done = 1'b0;
    logic        i_doneR = 1'b0;
`ifdef EQ_FLAT_EN
    logic        i_flat = 1'b0;
`endif
    logic [15:0] o_gain;
    logic [2:0]  o_set_gain;
    logic [15:0] o_gain_view;
    logic        o_pending;

    int checks = 0;
    int failures = 0;

    eq_gain_scheduler dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_band     (i_band),
        .i_inc      (i_inc),
        .i_dec      (i_dec),
        .i_dsp_done (i_dsp_done),
        .i_doneR    (i_doneR),
`ifdef EQ_FLAT_EN
        .i_flat     (i_flat),
`endif
        .o_gain     (o_gain),
        .o_set_gain (o_set_gain),
        .o_gain_view(o_gain_view),
        .o_pending  (o_pending)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        repeat (2) tick();
        i_rst = 1'b0;
    endtask

    task automatic pulse_edit(input logic [2:0] b, input logic inc, input logic dec);
        i_band = b;
        i_inc  = inc;
        i_dec  = dec;
        tick();
        i_inc  = 1'b0;
        i_dec  = 1'b0;
    endtask

    // One sample gap: captures band/gain after the latch edge, band one and two edges later.
    task automatic run_gap(output logic [2:0] s1, output logic [15:0] g1,
                           output logic [2:0] s2, output logic [2:0] s3);
        i_dsp_done = 1'b1;
        tick();
        i_dsp_done = 1'b0;
        s1 = o_set_gain;
        g1 = o_gain;
        tick();
        s2 = o_set_gain;
        tick();
        s3 = o_set_gain;
        repeat (8) tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (o_set_gain !== 3'd0) begin failures++; $display("FAIL reset_set_gain got %0d want 0", o_set_gain); end
        checks++; if (o_gain !== 16'h0000) begin failures++; $display("FAIL reset_gain got %h want 0000", o_gain); end
        checks++; if (o_pending !== 1'b1) begin failures++; $display("FAIL reset_pending got %b want 1", o_pending); end
        for (int b = 1; b <= 6; b++) begin
            i_band = 3'(b);
            #1;
            checks++; if (o_gain_view !== 16'h8000) begin failures++; $display("FAIL reset_view band %0d got %h want 8000", b, o_gain_view); end
        end
        i_band = 3'd0;
        #1;
        checks++; if (o_gain_view !== 16'h0000) begin failures++; $display("FAIL view_band0 got %h want 0000", o_gain_view); end
        i_band = 3'd7;
        #1;
        checks++; if (o_gain_view !== 16'h0000) begin failures++; $display("FAIL view_band7 got %h want 0000", o_gain_view); end
        i_dsp_done = 1'b1;
        tick();
        i_dsp_done = 1'b0;
        checks++; if (o_set_gain !== 3'd1) begin failures++; $display("FAIL midload_start got %0d want 1", o_set_gain); end
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        checks++; if (o_set_gain !== 3'd0) begin failures++; $display("FAIL midload_reset_set got %0d want 0", o_set_gain); end
        checks++; if (o_gain !== 16'h0000) begin failures++; $display("FAIL midload_reset_gain got %h want 0000", o_gain); end
        tick();
    endtask

    task automatic test_sync_all();
        logic [2:0] s1, s2, s3;
        logic [15:0] g1;
        do_reset();
        for (int b = 1; b <= 6; b++) begin
            run_gap(s1, g1, s2, s3);
            checks++; if (s1 !== 3'(b)) begin failures++; $display("FAIL sync_band gap %0d got %0d want %0d", b, s1, b); end
            checks++; if (g1 !== 16'h8000) begin failures++; $display("FAIL sync_gain gap %0d got %h want 8000", b, g1); end
            checks++; if (s2 !== 3'(b)) begin failures++; $display("FAIL sync_hold gap %0d got %0d want %0d", b, s2, b); end
            checks++; if (s3 !== 3'd0) begin failures++; $display("FAIL sync_release gap %0d got %0d want 0", b, s3); end
            repeat (25) tick();
        end
        checks++; if (o_pending !== 1'b0) begin failures++; $display("FAIL sync_pending got %b want 0", o_pending); end
        run_gap(s1, g1, s2, s3);
        checks++; if (s1 !== 3'd0) begin failures++; $display("FAIL clean_gap got %0d want 0", s1); end
    endtask

    task automatic test_saturate();
        logic [2:0] s1, s2, s3;
        logic [15:0] g1;
        i_band = 3'd3;
        i_inc = 1'b1;
        tick();
        i_inc = 1'b0;
        checks++; if (o_gain_view !== 16'h8800) begin failures++; $display("FAIL inc_once got %h want 8800", o_gain_view); end
        checks++; if (o_pending !== 1'b1) begin failures++; $display("FAIL edit_pending got %b want 1", o_pending); end
        i_inc = 1'b1;
        repeat (19) tick();
        i_inc = 1'b0;
        checks++; if (o_gain_view !== 16'hF000) begin failures++; $display("FAIL inc_sat got %h want F000", o_gain_view); end
        i_dec = 1'b1;
        repeat (20) tick();
        i_dec = 1'b0;
        checks++; if (o_gain_view !== 16'h5000) begin failures++; $display("FAIL dec_20 got %h want 5000", o_gain_view); end
        i_dec = 1'b1;
        repeat (12) tick();
        i_dec = 1'b0;
        checks++; if (o_gain_view !== 16'h0000) begin failures++; $display("FAIL dec_sat got %h want 0000", o_gain_view); end
        pulse_edit(3'd3, 1'b1, 1'b1);
        checks++; if (o_gain_view !== 16'h0000) begin failures++; $display("FAIL inc_and_dec got %h want 0000", o_gain_view); end
        run_gap(s1, g1, s2, s3);
        checks++; if (s1 !== 3'd3) begin failures++; $display("FAIL sat_load_band got %0d want 3", s1); end
        checks++; if (g1 !== 16'h0000) begin failures++; $display("FAIL sat_load_gain got %h want 0000", g1); end
    endtask

    task automatic test_rotation();
        logic [2:0] s1, s2, s3;
        logic [15:0] g1;
        do_reset();
        for (int b = 1; b <= 6; b++) run_gap(s1, g1, s2, s3);
        pulse_edit(3'd5, 1'b1, 1'b0);
        run_gap(s1, g1, s2, s3);
        checks++; if (s1 !== 3'd5) begin failures++; $display("FAIL rot_prep got %0d want 5", s1); end
        pulse_edit(3'd2, 1'b1, 1'b0);
        pulse_edit(3'd5, 1'b1, 1'b0);
        run_gap(s1, g1, s2, s3);
        checks++; if (s1 !== 3'd2) begin failures++; $display("FAIL rot_first got %0d want 2", s1); end
        checks++; if (g1 !== 16'h8800) begin failures++; $display("FAIL rot_first_gain got %h want 8800", g1); end
        run_gap(s1, g1, s2, s3);
        checks++; if (s1 !== 3'd5) begin failures++; $display("FAIL rot_second got %0d want 5", s1); end
        checks++; if (g1 !== 16'h9000) begin failures++; $display("FAIL rot_second_gain got %h want 9000", g1); end
        checks++; if (o_pending !== 1'b0) begin failures++; $display("FAIL rot_pending got %b want 0", o_pending); end
    endtask

    task automatic test_abort();
        logic [2:0] s1, s2, s3;
        logic [15:0] g1;
        pulse_edit(3'd1, 1'b1, 1'b0);
        pulse_edit(3'd6, 1'b0, 1'b1);
        i_dsp_done = 1'b1;
        i_doneR = 1'b1;
        tick();
        i_dsp_done = 1'b0;
        i_doneR = 1'b0;
        checks++; if (o_set_gain !== 3'd0) begin failures++; $display("FAIL done_with_doneR got %0d want 0", o_set_gain); end
        i_dsp_done = 1'b1;
        tick();
        i_dsp_done = 1'b0;
        checks++; if (o_set_gain !== 3'd6) begin failures++; $display("FAIL abort_start got %0d want 6", o_set_gain); end
        checks++; if (o_gain !== 16'h7800) begin failures++; $display("FAIL abort_gain got %h want 7800", o_gain); end
        i_doneR = 1'b1;
        tick();
        i_doneR = 1'b0;
        checks++; if (o_set_gain !== 3'd0) begin failures++; $display("FAIL abort_release got %0d want 0", o_set_gain); end
        checks++; if (o_pending !== 1'b1) begin failures++; $display("FAIL abort_pending got %b want 1", o_pending); end
        repeat (5) tick();
        run_gap(s1, g1, s2, s3);
        checks++; if (s1 !== 3'd6) begin failures++; $display("FAIL abort_retry got %0d want 6", s1); end
        checks++; if (s3 !== 3'd0) begin failures++; $display("FAIL abort_retry_end got %0d want 0", s3); end
        run_gap(s1, g1, s2, s3);
        checks++; if (s1 !== 3'd1) begin failures++; $display("FAIL abort_next got %0d want 1", s1); end
        checks++; if (g1 !== 16'h8800) begin failures++; $display("FAIL abort_next_gain got %h want 8800", g1); end
    endtask

    task automatic test_edit_during_load();
        logic [2:0] s1, s2, s3;
        logic [15:0] g1;
        do_reset();
        for (int b = 1; b <= 3; b++) run_gap(s1, g1, s2, s3);
        i_dsp_done = 1'b1;
        tick();
        i_dsp_done = 1'b0;
        checks++; if (o_set_gain !== 3'd4) begin failures++; $display("FAIL mid_start got %0d want 4", o_set_gain); end
        i_band = 3'd4;
        i_inc = 1'b1;
        i_dsp_done = 1'b1;
        tick();
        i_inc = 1'b0;
        i_dsp_done = 1'b0;
        checks++; if (o_set_gain !== 3'd4) begin failures++; $display("FAIL mid_hold got %0d want 4", o_set_gain); end
        checks++; if (o_gain !== 16'h8000) begin failures++; $display("FAIL mid_latched got %h want 8000", o_gain); end
        tick();
        checks++; if (o_set_gain !== 3'd0) begin failures++; $display("FAIL mid_end got %0d want 0", o_set_gain); end
        checks++; if (o_gain_view !== 16'h8800) begin failures++; $display("FAIL mid_view got %h want 8800", o_gain_view); end
        repeat (5) tick();
        run_gap(s1, g1, s2, s3);
        checks++; if (s1 !== 3'd5) begin failures++; $display("FAIL mid_next5 got %0d want 5", s1); end
        run_gap(s1, g1, s2, s3);
        checks++; if (s1 !== 3'd6) begin failures++; $display("FAIL mid_next6 got %0d want 6", s1); end
        run_gap(s1, g1, s2, s3);
        checks++; if (s1 !== 3'd4) begin failures++; $display("FAIL mid_reload got %0d want 4", s1); end
        checks++; if (g1 !== 16'h8800) begin failures++; $display("FAIL mid_reload_gain got %h want 8800", g1); end
        checks++; if (o_pending !== 1'b0) begin failures++; $display("FAIL mid_pending got %b want 0", o_pending); end
    endtask

`ifdef EQ_FLAT_EN
    task automatic test_flat();
        logic [2:0] s1, s2, s3;
        logic [15:0] g1;
        do_reset();
        for (int b = 1; b <= 6; b++) run_gap(s1, g1, s2, s3);
        for (int b = 1; b <= 6; b++) begin
            i_band = 3'(b);
            i_inc = 1'b1;
            repeat (4) tick();
            i_inc = 1'b0;
            checks++; if (o_gain_view !== 16'hA000) begin failures++; $display("FAIL flat_prep band %0d got %h want A000", b, o_gain_view); end
        end
        i_band = 3'd2;
        i_inc = 1'b1;
        i_flat = 1'b1;
        tick();
        i_inc = 1'b0;
        i_flat = 1'b0;
        for (int b = 1; b <= 6; b++) begin
            i_band = 3'(b);
            #1;
            checks++; if (o_gain_view !== 16'h8000) begin failures++; $display("FAIL flat_view band %0d got %h want 8000", b, o_gain_view); end
        end
        for (int b = 1; b <= 6; b++) begin
            run_gap(s1, g1, s2, s3);
            checks++; if (s1 !== 3'(b)) begin failures++; $display("FAIL flat_band gap %0d got %0d want %0d", b, s1, b); end
            checks++; if (g1 !== 16'h8000) begin failures++; $display("FAIL flat_gain gap %0d got %h want 8000", b, g1); end
        end
        checks++; if (o_pending !== 1'b0) begin failures++; $display("FAIL flat_pending got %b want 0", o_pending); end
    endtask
`endif

    initial begin
        test_reset();
        test_sync_all();
        test_saturate();
        test_rotation();
        test_abort();
        test_edit_during_load();
`ifdef EQ_FLAT_EN
        test_flat();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
